// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: owns HI/LO, sequences mult/div through a busy countdown.
// Optional `MDU_DIV0_KEEP_EN: div/divu by zero skips BUSY and leaves HI/LO untouched.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mf_out,
  output logic        dbg_state
);

  // Handshake: start is a one-cycle request accepted only in IDLE; while busy,
  // the hazard unit holds D via md_stall and must not issue another start.

`ifdef MDU_DIV0_KEEP_EN
  localparam bit DIV0_KEEP = 1'b1;
`else
  localparam bit DIV0_KEEP = 1'b0;
`endif

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] hi_tmp, lo_tmp;
  logic        is_mul, is_div, div0, launch;
  logic [63:0] a_sx, b_sx, mul_s, mul_u;
  logic [31:0] dsor, q_s, r_s, q_u, r_u;
  logic [31:0] res_hi, res_lo;

  assign is_mul = (op == 4'd1) || (op == 4'd2);
  assign is_div = (op == 4'd3) || (op == 4'd4);
  assign div0   = is_div && (B == 32'd0);
  assign launch = start && (state == IDLE) && (is_mul || (is_div && !(DIV0_KEEP && div0)));

  // Divisor forced to 1 on zero so the divider never sees /0; result is overridden below.
  assign dsor  = (B == 32'd0) ? 32'd1 : B;
  assign a_sx  = {{32{A[31]}}, A};
  assign b_sx  = {{32{B[31]}}, B};
  assign mul_s = $signed(a_sx) * $signed(b_sx);
  assign mul_u = {32'd0, A} * {32'd0, B};
  assign q_s   = $signed(A) / $signed(dsor);
  assign r_s   = $signed(A) % $signed(dsor);
  assign q_u   = A / dsor;
  assign r_u   = A % dsor;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      4'd1: {res_hi, res_lo} = mul_s;
      4'd2: {res_hi, res_lo} = mul_u;
      4'd3: begin
        if (B == 32'd0) begin
          res_hi = A;
          res_lo = 32'hFFFF_FFFF;
        end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = r_s;
          res_lo = q_s;
        end
      end
      4'd4: begin
        if (B == 32'd0) begin
          res_hi = A;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = r_u;
          res_lo = q_u;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == BUSY);
    dbg_state = state;
    md_stall  = D_md & (busy | (start & (is_mul | is_div)));
    mf_out    = (op == 4'd7) ? HI : LO;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      HI     <= '0;
      LO     <= '0;
      hi_tmp <= '0;
      lo_tmp <= '0;
      cnt    <= '0;
    end else if (state == IDLE) begin
      if (launch) begin
        hi_tmp <= res_hi;
        lo_tmp <= res_lo;
        cnt    <= is_mul ? MULT_N : DIV_N;
      end else if (start && op == 4'd5) begin
        HI <= A;
      end else if (start && op == 4'd6) begin
        LO <= A;
      end
    end else begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        HI <= hi_tmp;
        LO <= lo_tmp;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: reference model feeds an expected queue,
// compared against HI/LO when each operation retires.
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a_val, b_val;
  logic        d_md;
  logic        busy, md_stall, dbg_state;
  logic [31:0] hi, lo, mf_out;

  logic [63:0] exp_q[$];
  logic [31:0] exp_hi, exp_lo;
  int          n_cmp, n_err;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(a_val), .B(b_val),
    .D_md(d_md), .busy(busy), .md_stall(md_stall), .HI(hi), .LO(lo),
    .mf_out(mf_out), .dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sign-magnitude reference; {hi, lo}.
  function automatic logic [63:0] ref_md(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic [31:0] mx, my, mq, mr, q, r;
    ref_md = '0;
    case (o)
      4'd1: begin
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ref_md = sx * sy;
      end
      4'd2: ref_md = {32'd0, x} * {32'd0, y};
      4'd3, 4'd4: begin
        if (y == 32'd0) ref_md = {x, 32'hFFFF_FFFF};
        else if (o == 4'd4) ref_md = {x % y, x / y};
        else begin
          mx = x[31] ? (32'd0 - x) : x;
          my = y[31] ? (32'd0 - y) : y;
          mq = mx / my;
          mr = mx % my;
          q  = (x[31] ^ y[31]) ? (32'd0 - mq) : mq;
          r  = x[31] ? (32'd0 - mr) : mr;
          ref_md = {r, q};
        end
      end
      default: ref_md = '0;
    endcase
  endfunction

  // Starts in mid-cycle, ends mid-cycle of the first IDLE cycle after retirement.
  task automatic do_op(input logic [3:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                       input logic t_dmd);
    int n_exp, nb, ns, guard;
    logic [63:0] r;
    n_exp = (t_op <= 4'd2) ? MULT_N : DIV_N;
    r = ref_md(t_op, t_a, t_b);
`ifdef MDU_DIV0_KEEP_EN
    if (t_op >= 4'd3 && t_b == 32'd0) begin
      n_exp = 0;
      r = {exp_hi, exp_lo};
    end
`endif
    exp_q.push_back(r);
    start = 1'b1; op = t_op; a_val = t_a; b_val = t_b; d_md = t_dmd;
    #1;
    check("stall_start", md_stall, t_dmd);
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    #1;
    nb = 0; ns = 0; guard = 0;
    while (busy && guard < 40) begin
      nb++;
      if (md_stall) ns++;
      @(negedge clk);
      #1;
      guard++;
    end
    check("busy_cycles", nb, n_exp);
    check("stall_cycles", ns, t_dmd ? n_exp : 0);
    check("stall_after", md_stall, 1'b0);
    r = exp_q.pop_front();
    check("hi", hi, r[63:32]);
    check("lo", lo, r[31:0]);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    d_md = 1'b0;
  endtask

  task automatic do_mt(input logic [3:0] t_op, input logic [31:0] t_a);
    logic [63:0] r;
    if (t_op == 4'd5) exp_hi = t_a;
    else              exp_lo = t_a;
    exp_q.push_back({exp_hi, exp_lo});
    start = 1'b1; op = t_op; a_val = t_a; d_md = 1'b1;
    #1;
    check("mt_stall", md_stall, 1'b0);
    @(negedge clk);
    start = 1'b0; op = (t_op == 4'd5) ? 4'd7 : 4'd8; d_md = 1'b0;
    #1;
    check("mt_busy", busy, 1'b0);
    check("mt_mf", mf_out, t_a);
    r = exp_q.pop_front();
    check("mt_hi", hi, r[63:32]);
    check("mt_lo", lo, r[31:0]);
  endtask

  task automatic check_mf;
    op = 4'd7; #1;
    check("mfhi", mf_out, exp_hi);
    op = 4'd8; #1;
    check("mflo", mf_out, exp_lo);
    op = 4'd0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; op = 4'd0; a_val = '0; b_val = '0; d_md = 1'b0;
    exp_hi = '0; exp_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_stall", md_stall, 1'b0);

    do_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("plan_mult_hi", hi, 32'hFFFF_FFFF);
    check("plan_mult_lo", lo, 32'hFFFF_FFFA);
    check_mf();

    do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("plan_div_lo", lo, 32'hFFFF_FFFD);
    check("plan_div_hi", hi, 32'hFFFF_FFFF);
    do_op(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("plan_divu_lo", lo, 32'h7FFF_FFFC);
    check("plan_divu_hi", hi, 32'd1);

    // multu with D_md held: start cycle plus MULT_N busy cycles stalled.
    do_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("plan_multu_hi", hi, 32'hFFFF_FFFE);
    check("plan_multu_lo", lo, 32'd1);

    // mthi straight after a retiring op, then mtlo the next cycle.
    do_mt(4'd5, 32'hAAAA_0000);
    do_mt(4'd6, 32'h0000_5555);
    check("plan_mt_hi", hi, 32'hAAAA_0000);
    check("plan_mt_lo", lo, 32'h0000_5555);

    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);

    do_op(4'd3, 32'd9, 32'd0, 1'b1);
`ifdef MDU_DIV0_KEEP_EN
    check("div0_hi", hi, 32'h8000_0000 & 32'd0);
`else
    check("div0_hi", hi, 32'd9);
    check("div0_lo", lo, 32'hFFFF_FFFF);
`endif
    do_op(4'd4, 32'h1234_5678, 32'd0, 1'b0);

    // Abort: reset during the third busy cycle.
    start = 1'b1; op = 4'd1; a_val = 32'd7; b_val = 32'd6;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    check("abort_busy_pre", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    exp_hi = '0; exp_lo = '0;
    do_mt(4'd5, 32'h0000_1234);
    check("abort_mthi", hi, 32'h0000_1234);

    for (int i = 0; i < 12; i++) begin
      logic [3:0]  r_op;
      logic [31:0] r_a, r_b;
      r_op = 4'($urandom_range(1, 4));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 9));
      do_op(r_op, r_a, r_b, 1'($urandom_range(0, 1)));
      check_mf();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
